// File: rtl/sync_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, blank,
// frame-start, vertical-blank interrupt and playfield flash outputs.
module sync_timing_gen #(
  parameter int H_TOTAL   = 384,
  parameter int V_TOTAL   = 262,
  parameter int FLASH_DIV = 16
) (
  input  logic       Clk6,
  input  logic       Reset_n,
  input  logic       FlashEn,
  input  logic       IrqAck,
  output logic [8:0] HCount,
  output logic [8:0] VCount,
  output logic       HSync,
  output logic       VSync,
  output logic       HBlank_n,
  output logic       VBlank_n,
  output logic       Flash,
  output logic       FrameStart,
  output logic       VBlankIrq
);

  localparam int              CW     = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [8:0]      H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0]      V_LAST = 9'(V_TOTAL - 1);
  localparam logic [CW-1:0]   F_LAST = CW'(FLASH_DIV - 1);

  logic [CW-1:0] frame_cnt;
  logic          h_wrap;
  logic          v_wrap;
  logic [8:0]    h_next;
  logic [8:0]    v_next;

  // Decodes are taken from the next counter values so every registered
  // output lines up with the HCount/VCount it describes.
  always_comb begin
    h_wrap = (HCount == H_LAST);
    v_wrap = h_wrap && (VCount == V_LAST);
    h_next = h_wrap ? 9'd0 : HCount + 9'd1;
    v_next = VCount;
    if (v_wrap) begin
      v_next = 9'd0;
    end else if (h_wrap) begin
      v_next = VCount + 9'd1;
    end
  end

  always_ff @(posedge Clk6 or negedge Reset_n) begin
    if (!Reset_n) begin
      HCount     <= 9'd0;
      VCount     <= 9'd0;
      HSync      <= 1'b0;
      VSync      <= 1'b0;
      HBlank_n   <= 1'b1;
      VBlank_n   <= 1'b1;
      FrameStart <= 1'b0;
    end else begin
      HCount     <= h_next;
      VCount     <= v_next;
      HSync      <= (h_next >= 9'd288) && (h_next <= 9'd319);
      HBlank_n   <= !((h_next >= 9'd256) && (h_next <= 9'd383));
      VSync      <= (v_next >= 9'd232) && (v_next <= 9'd235);
      VBlank_n   <= !((v_next >= 9'd224) && (v_next <= 9'd261));
      FrameStart <= v_wrap;
    end
  end

  // Setting the interrupt takes priority over an acknowledge on the same edge.
  always_ff @(posedge Clk6 or negedge Reset_n) begin
    if (!Reset_n) begin
      VBlankIrq <= 1'b0;
    end else if (h_wrap && (v_next == 9'd224)) begin
      VBlankIrq <= 1'b1;
    end else if (IrqAck) begin
      VBlankIrq <= 1'b0;
    end
  end

  always_ff @(posedge Clk6 or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_cnt <= '0;
      Flash     <= 1'b0;
    end else if (!FlashEn) begin
      frame_cnt <= '0;
      Flash     <= 1'b0;
    end else if (v_wrap) begin
      if (frame_cnt == F_LAST) begin
        frame_cnt <= '0;
        Flash     <= !Flash;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_timing_gen.sv
// Bench for sync_timing_gen: two shortened-raster instances checked against an
// arithmetic raster model plus directed boundary checks.
module tb_sync_timing_gen;

  localparam int HT0 = 384;
  localparam int VT0 = 4;
  localparam int FD0 = 2;
  localparam int HT1 = 4;
  localparam int VT1 = 262;
  localparam int FD1 = 3;

  logic       clk6 = 1'b0;
  logic       rst0_n, rst1_n, flash0, flash1, ack0, ack1;
  logic [8:0] h0, v0, h1, v1;
  logic       hs0, vs0, hb0_n, vb0_n, fl0, fs0, irq0;
  logic       hs1, vs1, hb1_n, vb1_n, fl1, fs1, irq1;

  int checks = 0;
  int errors = 0;

  int tm[2];
  int wrap_cnt[2];
  bit irq_m[2];

  always #5 clk6 = ~clk6;

  sync_timing_gen #(.H_TOTAL(HT0), .V_TOTAL(VT0), .FLASH_DIV(FD0)) dut0 (
    .Clk6(clk6), .Reset_n(rst0_n), .FlashEn(flash0), .IrqAck(ack0),
    .HCount(h0), .VCount(v0), .HSync(hs0), .VSync(vs0), .HBlank_n(hb0_n),
    .VBlank_n(vb0_n), .Flash(fl0), .FrameStart(fs0), .VBlankIrq(irq0)
  );

  sync_timing_gen #(.H_TOTAL(HT1), .V_TOTAL(VT1), .FLASH_DIV(FD1)) dut1 (
    .Clk6(clk6), .Reset_n(rst1_n), .FlashEn(flash1), .IrqAck(ack1),
    .HCount(h1), .VCount(v1), .HSync(hs1), .VSync(vs1), .HBlank_n(hb1_n),
    .VBlank_n(vb1_n), .Flash(fl1), .FrameStart(fs1), .VBlankIrq(irq1)
  );

  function automatic int h_tot(int i);
    return (i == 0) ? HT0 : HT1;
  endfunction

  function automatic int v_tot(int i);
    return (i == 0) ? VT0 : VT1;
  endfunction

  function automatic int e_h(int i);
    return tm[i] % h_tot(i);
  endfunction

  function automatic int e_v(int i);
    return (tm[i] / h_tot(i)) % v_tot(i);
  endfunction

  // {HSync, HBlank_n, VSync, VBlank_n, FrameStart} implied by the raster position
  function automatic logic [4:0] e_dec(int i);
    int h, v;
    h = e_h(i);
    v = e_v(i);
    return {(h >= 288 && h <= 319), !(h >= 256 && h <= 383),
            (v >= 232 && v <= 235), !(v >= 224 && v <= 261),
            (tm[i] > 0 && h == 0 && v == 0)};
  endfunction

  function automatic logic e_flash(int i);
    return ((wrap_cnt[i] / ((i == 0) ? FD0 : FD1)) % 2) == 1;
  endfunction

  // Model: count edges since release; position, frame wraps and the
  // interrupt follow from that count.
  task automatic model_edge(input int i, input logic rn, input logic fe, input logic ack);
    int h, v;
    if (!rn) begin
      tm[i] = 0;
      wrap_cnt[i] = 0;
      irq_m[i] = 1'b0;
    end else begin
      tm[i] = tm[i] + 1;
      h = e_h(i);
      v = e_v(i);
      if (!fe) wrap_cnt[i] = 0;
      else if (h == 0 && v == 0) wrap_cnt[i] = wrap_cnt[i] + 1;
      if (h == 0 && v == 224) irq_m[i] = 1'b1;
      else if (ack) irq_m[i] = 1'b0;
    end
  endtask

  always @(posedge clk6 or negedge rst0_n) model_edge(0, rst0_n, flash0, ack0);
  always @(posedge clk6 or negedge rst1_n) model_edge(1, rst1_n, flash1, ack1);

  task automatic pulse_reset(input int i);
    @(negedge clk6);
    if (i == 0) rst0_n = 1'b0; else rst1_n = 1'b0;
    repeat (2) @(negedge clk6);
    if (i == 0) rst0_n = 1'b1; else rst1_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [24:0] exp_rst;
    rst0_n = 1'b0; rst1_n = 1'b0;
    flash0 = 1'b1; flash1 = 1'b1; ack0 = 1'b1; ack1 = 1'b1;
    repeat (3) @(negedge clk6);
    exp_rst = {9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if ({h0, v0, hs0, vs0, hb0_n, vb0_n, fl0, fs0, irq0} !== exp_rst) begin
      errors++;
      $display("[TB] FAIL reset0 got %h exp %h", {h0, v0, hs0, vs0, hb0_n, vb0_n, fl0, fs0, irq0}, exp_rst);
    end
    checks++;
    if ({h1, v1, hs1, vs1, hb1_n, vb1_n, fl1, fs1, irq1} !== exp_rst) begin
      errors++;
      $display("[TB] FAIL reset1 got %h exp %h", {h1, v1, hs1, vs1, hb1_n, vb1_n, fl1, fs1, irq1}, exp_rst);
    end
    flash0 = 1'b0; flash1 = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
  endtask

  task automatic test_horizontal();
    int hs_cycles = 0;
    pulse_reset(0);
    for (int k = 1; k <= 2 * HT0 * VT0 + 8; k++) begin
      @(negedge clk6);
      if (k <= HT0 && hs0) hs_cycles++;
      checks++;
      if (h0 !== 9'(e_h(0)) || v0 !== 9'(e_v(0))) begin
        errors++;
        $display("[TB] FAIL pos0 k=%0d got %0d,%0d exp %0d,%0d", k, h0, v0, e_h(0), e_v(0));
      end
      checks++;
      if ({hs0, hb0_n, vs0, vb0_n, fs0} !== e_dec(0)) begin
        errors++;
        $display("[TB] FAIL dec0 k=%0d got %b exp %b", k, {hs0, hb0_n, vs0, vb0_n, fs0}, e_dec(0));
      end
      checks++;
      if (fl0 !== e_flash(0) || irq0 !== irq_m[0]) begin
        errors++;
        $display("[TB] FAIL flirq0 k=%0d got %b%b exp %b%b", k, fl0, irq0, e_flash(0), irq_m[0]);
      end
      if (k == 255 || k == 256) begin
        checks++;
        if (hb0_n !== (k == 255)) begin
          errors++;
          $display("[TB] FAIL hblank_edge k=%0d got %b", k, hb0_n);
        end
      end
      if (k == HT0) begin
        checks++;
        if (h0 !== 9'd0 || v0 !== 9'd1) begin
          errors++;
          $display("[TB] FAIL line_wrap got %0d,%0d exp 0,1", h0, v0);
        end
      end
      ack0 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 799) == 0) flash0 = !flash0;
    end
    checks++;
    if (hs_cycles != 32) begin
      errors++;
      $display("[TB] FAIL hsync_width got %0d exp 32", hs_cycles);
    end
    flash0 = 1'b0; ack0 = 1'b0;
  endtask

  task automatic test_vertical();
    int vb_cycles = 0, vs_cycles = 0, fs_pulses = 0, fs_at = -1;
    pulse_reset(1);
    for (int k = 1; k <= HT1 * VT1 + 8; k++) begin
      @(negedge clk6);
      if (k <= HT1 * VT1) begin
        if (!vb1_n) vb_cycles++;
        if (vs1) vs_cycles++;
        if (fs1) begin fs_pulses++; fs_at = k; end
      end
      checks++;
      if (h1 !== 9'(e_h(1)) || v1 !== 9'(e_v(1))) begin
        errors++;
        $display("[TB] FAIL pos1 k=%0d got %0d,%0d exp %0d,%0d", k, h1, v1, e_h(1), e_v(1));
      end
      checks++;
      if ({hs1, hb1_n, vs1, vb1_n, fs1} !== e_dec(1)) begin
        errors++;
        $display("[TB] FAIL dec1 k=%0d got %b exp %b", k, {hs1, hb1_n, vs1, vb1_n, fs1}, e_dec(1));
      end
    end
    checks++;
    if (vb_cycles != 38 * HT1 || vs_cycles != 4 * HT1) begin
      errors++;
      $display("[TB] FAIL vblank_vsync_len got %0d/%0d exp %0d/%0d", vb_cycles, vs_cycles, 38 * HT1, 4 * HT1);
    end
    checks++;
    if (fs_pulses != 1 || fs_at != HT1 * VT1) begin
      errors++;
      $display("[TB] FAIL frame_start got %0d pulses at %0d exp 1 at %0d", fs_pulses, fs_at, HT1 * VT1);
    end
  endtask

  task automatic test_irq();
    int n;
    pulse_reset(1);
    for (int k = 1; k <= 2 * HT1 * VT1; k++) begin
      @(negedge clk6);
      checks++;
      if (irq1 !== irq_m[1]) begin
        errors++;
        $display("[TB] FAIL irq_rand k=%0d got %b exp %b", k, irq1, irq_m[1]);
      end
      ack1 = ($urandom_range(0, 63) == 0);
    end
    ack1 = 1'b0;
    n = 0;
    while (n < 1200 && !(h1 == 9'(HT1 - 1) && v1 == 9'd223)) begin
      @(negedge clk6);
      n++;
    end
    checks++;
    if (!(h1 == 9'(HT1 - 1) && v1 == 9'd223)) begin
      errors++;
      $display("[TB] FAIL irq_wait timeout at %0d,%0d", h1, v1);
    end
    ack1 = 1'b1;
    @(negedge clk6);
    checks++;
    if (irq1 !== 1'b1 || h1 !== 9'd0 || v1 !== 9'd224) begin
      errors++;
      $display("[TB] FAIL irq_set_wins got irq=%b at %0d,%0d exp 1 at 0,224", irq1, h1, v1);
    end
    @(negedge clk6);
    checks++;
    if (irq1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_ack got %b exp 0", irq1);
    end
    ack1 = 1'b0;
  endtask

  task automatic test_flash();
    int rise_at = -1, fall_at = -1;
    logic prev = 1'b0;
    flash1 = 1'b1;
    pulse_reset(1);
    for (int k = 1; k <= 9 * HT1 * VT1 + 2; k++) begin
      @(negedge clk6);
      if (fl1 && !prev && rise_at < 0) rise_at = k;
      if (!fl1 && prev && fall_at < 0) fall_at = k;
      prev = fl1;
      checks++;
      if (fl1 !== e_flash(1)) begin
        errors++;
        $display("[TB] FAIL flash_run k=%0d got %b exp %b", k, fl1, e_flash(1));
      end
    end
    checks++;
    if (rise_at != 3 * HT1 * VT1 || fall_at != 6 * HT1 * VT1) begin
      errors++;
      $display("[TB] FAIL flash_timing got rise %0d fall %0d exp %0d %0d", rise_at, fall_at, 3 * HT1 * VT1, 6 * HT1 * VT1);
    end
    checks++;
    if (fl1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flash_before_drop got %b exp 1", fl1);
    end
    flash1 = 1'b0;
    @(negedge clk6);
    checks++;
    if (fl1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flash_drop got %b exp 0", fl1);
    end
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 1499) == 0) flash1 = !flash1;
      @(negedge clk6);
      checks++;
      if (fl1 !== e_flash(1)) begin
        errors++;
        $display("[TB] FAIL flash_rand k=%0d got %b exp %b", k, fl1, e_flash(1));
      end
    end
    flash1 = 1'b0;
  endtask

  task automatic test_async_reset();
    int n;
    flash0 = 1'b1;
    pulse_reset(0);
    n = 0;
    while (n < 5000 && !(fl0 && h0 == 9'd300)) begin
      @(negedge clk6);
      n++;
    end
    checks++;
    if (!(fl0 && hs0 && h0 == 9'd300)) begin
      errors++;
      $display("[TB] FAIL async0_setup got fl=%b hs=%b h=%0d", fl0, hs0, h0);
    end
    #2 rst0_n = 1'b0;
    #1;
    checks++;
    if ({hs0, fl0, hb0_n, h0, v0} !== {1'b0, 1'b0, 1'b1, 9'd0, 9'd0}) begin
      errors++;
      $display("[TB] FAIL async0_clear got hs=%b fl=%b hb_n=%b h=%0d v=%0d", hs0, fl0, hb0_n, h0, v0);
    end
    @(negedge clk6);
    rst0_n = 1'b1;
    flash0 = 1'b0;
    @(negedge clk6);
    checks++;
    if (h0 !== 9'd1 || v0 !== 9'd0) begin
      errors++;
      $display("[TB] FAIL async0_restart got %0d,%0d exp 1,0", h0, v0);
    end

    ack1 = 1'b0;
    pulse_reset(1);
    n = 0;
    while (n < 1200 && !(v1 == 9'd233 && h1 == 9'd2)) begin
      @(negedge clk6);
      n++;
    end
    checks++;
    if (!(vs1 && irq1 && v1 == 9'd233)) begin
      errors++;
      $display("[TB] FAIL async1_setup got vs=%b irq=%b v=%0d", vs1, irq1, v1);
    end
    #2 rst1_n = 1'b0;
    #1;
    checks++;
    if ({vs1, irq1, vb1_n, h1, v1} !== {1'b0, 1'b0, 1'b1, 9'd0, 9'd0}) begin
      errors++;
      $display("[TB] FAIL async1_clear got vs=%b irq=%b vb_n=%b h=%0d v=%0d", vs1, irq1, vb1_n, h1, v1);
    end
    @(negedge clk6);
    rst1_n = 1'b1;
    @(negedge clk6);
    checks++;
    if (h1 !== 9'd1 || v1 !== 9'd0) begin
      errors++;
      $display("[TB] FAIL async1_restart got %0d,%0d exp 1,0", h1, v1);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_vertical();
    test_irq();
    test_flash();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
